// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the line-fill master state type.
// Optional build macro: CRITICAL_WORD_FIRST_EN selects wrapping bursts.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_BURST,
    ST_DATA_LAST,
    ST_ERR
  } fill_state_e;

  // Burst type for a line of lw words; wrapping when the critical word leads.
  function automatic logic [2:0] burst_code(input int unsigned lw);
`ifdef CRITICAL_WORD_FIRST_EN
    return (lw == 8) ? HBURST_WRAP8 : HBURST_WRAP4;
`else
    return (lw == 8) ? HBURST_INCR8 : HBURST_INCR4;
`endif
  endfunction

endpackage

// File: rtl/ahb_line_fill_master_if.sv
// AHB-Lite master/slave signal bundle used by the line-fill master.
interface ahb_line_fill_master_if;

  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hport;
  logic [1:0]  htrans;
  logic        hmastlock;
  logic [31:0] hwdata;
  logic        hready;
  logic        hresp;
  logic [31:0] hrdata;

  modport master (
    output haddr, hwrite, hsize, hburst, hport, htrans, hmastlock, hwdata,
    input  hready, hresp, hrdata
  );

  modport slave (
    input  haddr, hwrite, hsize, hburst, hport, htrans, hmastlock, hwdata,
    output hready, hresp, hrdata
  );

endinterface

// File: rtl/ahb_line_fill_master_fill_addr_gen.sv
// Beat address generator: holds the line base and current word index,
// wraps the index within the line and flags the final address phase.
// Optional build macro: CRITICAL_WORD_FIRST_EN starts at the requested word.
module fill_addr_gen #(
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                          hclk,
  input  logic                          hrstn,
  input  logic                          i_load,
  input  logic                          i_advance,
  input  logic [31:0]                   i_req_addr,
  output logic [31:0]                   o_addr,
  output logic [$clog2(LINE_WORDS)-1:0] o_idx,
  output logic                          o_last
);

  localparam int unsigned IDX_W = $clog2(LINE_WORDS);

  logic [31-IDX_W-2:0] r_base;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    w_start;
  logic                w_unused_addr;

`ifdef CRITICAL_WORD_FIRST_EN
  assign w_start = i_req_addr[IDX_W+1:2];
`else
  assign w_start = '0;
`endif

  // Offset bits are either the start index or ignored entirely.
  assign w_unused_addr = ^i_req_addr[IDX_W+1:0];

  // Latch line base on request; wrap-increment index on each accepted beat.
  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      r_base <= '0;
      r_idx  <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_base <= i_req_addr[31:IDX_W+2];
      r_idx  <= w_start;
      r_cnt  <= '0;
    end else if (i_advance) begin
      r_idx  <= r_idx + 1'b1;
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  assign o_addr = {r_base, r_idx, 2'b00};
  assign o_idx  = r_idx;
  assign o_last = (r_cnt == IDX_W'(LINE_WORDS - 1));

endmodule

// File: rtl/ahb_line_fill_master.sv
// I-cache line-fill AHB-Lite master: one read burst per miss, beats returned
// tagged with their word index, completion or error reported.
// Optional build macro: CRITICAL_WORD_FIRST_EN (wrap burst, requested word first).
//
// state        | meaning
// ST_IDLE      | ready for a miss request
// ST_ADDR      | first (NONSEQ) address phase, no data in flight
// ST_BURST     | SEQ address phases overlapping previous beat's data phase
// ST_DATA_LAST | final data phase, bus address phase idle
// ST_ERR       | second cycle of an error response pending
module ahb_line_fill_master
  import ahb_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4,
  parameter logic [3:0]  HPORT_VAL  = 4'b0010
) (
  input  logic                          hclk,
  input  logic                          hrstn,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [31:0]                   req_addr,
  ahb_line_fill_master_if.master        ahb,
  output logic                          fill_valid,
  output logic [$clog2(LINE_WORDS)-1:0] fill_idx,
  output logic [31:0]                   fill_data,
  output logic                          fill_last,
  output logic                          fill_err
);

  localparam int unsigned IDX_W = $clog2(LINE_WORDS);

  fill_state_e      r_state;
  fill_state_e      w_next;
  logic             w_load;
  logic             w_data_phase;
  logic             w_addr_acc;
  logic             w_data_done;
  logic             w_err_start;
  logic             w_last;
  logic [31:0]      w_addr;
  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] r_dp_idx;
  logic             r_fill_valid;
  logic [IDX_W-1:0] r_fill_idx;
  logic [31:0]      r_fill_data;
  logic             r_fill_last;
  logic             r_fill_err;

  assign w_load       = req_valid && req_ready;
  assign w_data_phase = (r_state == ST_BURST) || (r_state == ST_DATA_LAST);
  assign w_err_start  = w_data_phase && ahb.hresp && !ahb.hready;
  assign w_addr_acc   = ahb.hready && ((r_state == ST_ADDR) || (r_state == ST_BURST));
  assign w_data_done  = w_data_phase && ahb.hready && !ahb.hresp;

  fill_addr_gen #(.LINE_WORDS(LINE_WORDS)) u_addr_gen (
    .hclk       (hclk),
    .hrstn      (hrstn),
    .i_load     (w_load),
    .i_advance  (w_addr_acc),
    .i_req_addr (req_addr),
    .o_addr     (w_addr),
    .o_idx      (w_idx),
    .o_last     (w_last)
  );

  // State register.
  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (w_load) w_next = ST_ADDR;
      ST_ADDR:      if (ahb.hready) w_next = ST_BURST;
      ST_BURST: begin
        if (w_err_start)                w_next = ST_ERR;
        else if (ahb.hready && w_last)  w_next = ST_DATA_LAST;
      end
      ST_DATA_LAST: begin
        if (w_err_start)      w_next = ST_ERR;
        else if (ahb.hready)  w_next = ST_IDLE;
      end
      ST_ERR:       if (ahb.hready) w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  // Bus outputs; htrans drops to IDLE combinationally in the first error cycle.
  always_comb begin
    req_ready     = hrstn && (r_state == ST_IDLE);
    ahb.htrans    = HTRANS_IDLE;
    ahb.haddr     = '0;
    ahb.hburst    = HBURST_SINGLE;
    ahb.hwrite    = 1'b0;
    ahb.hsize     = HSIZE_WORD;
    ahb.hport     = HPORT_VAL;
    ahb.hmastlock = 1'b0;
    ahb.hwdata    = '0;
    case (r_state)
      ST_ADDR: begin
        ahb.htrans = HTRANS_NONSEQ;
        ahb.haddr  = w_addr;
        ahb.hburst = burst_code(LINE_WORDS);
      end
      ST_BURST: begin
        if (!w_err_start) begin
          ahb.htrans = HTRANS_SEQ;
          ahb.haddr  = w_addr;
          ahb.hburst = burst_code(LINE_WORDS);
        end
      end
      default: ;
    endcase
  end

  // Registered fill return; remembers which word each data phase belongs to.
  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      r_dp_idx     <= '0;
      r_fill_valid <= 1'b0;
      r_fill_idx   <= '0;
      r_fill_data  <= '0;
      r_fill_last  <= 1'b0;
      r_fill_err   <= 1'b0;
    end else begin
      if (w_addr_acc) r_dp_idx <= w_idx;
      r_fill_valid <= w_data_done;
      r_fill_last  <= w_data_done && (r_state == ST_DATA_LAST);
      r_fill_err   <= (r_state == ST_ERR) && ahb.hready;
      if (w_data_done) begin
        r_fill_idx  <= r_dp_idx;
        r_fill_data <= ahb.hrdata;
      end
    end
  end

  assign fill_valid = r_fill_valid;
  assign fill_idx   = r_fill_idx;
  assign fill_data  = r_fill_data;
  assign fill_last  = r_fill_last;
  assign fill_err   = r_fill_err;

endmodule
